// File: rtl/pd_output_stage.sv
// Output stage after the PD controller: scale by arithmetic shift, clamp to a DAC window,
// optionally slew-limit against the last accepted code, then hand off with arm/finished.
module pd_output_stage #(
  parameter int unsigned IN_WIDTH       = 32,
  parameter int unsigned DAC_WIDTH      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [IN_WIDTH-1:0]  i_pd_out,
  input  logic                        i_valid,
  input  logic        [4:0]           i_shift,
  input  logic signed [DAC_WIDTH-1:0] i_max,
  input  logic signed [DAC_WIDTH-1:0] i_min,
  input  logic        [DAC_WIDTH-1:0] i_max_step,
  input  logic                        i_dac_finished,
  output logic signed [DAC_WIDTH-1:0] o_dac_data,
  output logic                        o_dac_arm,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_clamped,
  output logic                        o_overrun,
  output logic                        o_timeout
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StShift, StClamp, StSlew, StArm} state_e;

  state_e state_q, state_d;

  logic                        valid_q;
  logic                        start;
  logic signed [IN_WIDTH-1:0]  value_q;
  logic        [4:0]           shift_q;
  logic signed [DAC_WIDTH-1:0] max_q, min_q, target_q, last_q, data_q;
  logic        [DAC_WIDTH-1:0] step_q;
  logic        [CntWidth-1:0]  cnt_q;
  logic                        arm_q, done_q, clamped_q, overrun_q, timeout_q;
  logic                        expired;

  assign start   = i_valid & ~valid_q;
  assign expired = (cnt_q == CntWidth'(TIMEOUT_CYCLES));

  // Clamp: upper bound first, lower bound second, so min wins on an inverted window.
  logic signed [IN_WIDTH-1:0]  max_ext, min_ext;
  logic                        hit_max, hit_min;
  logic signed [DAC_WIDTH-1:0] clamp_res;

  always_comb begin
    max_ext   = {{(IN_WIDTH - DAC_WIDTH){max_q[DAC_WIDTH-1]}}, max_q};
    min_ext   = {{(IN_WIDTH - DAC_WIDTH){min_q[DAC_WIDTH-1]}}, min_q};
    hit_max   = value_q > max_ext;
    hit_min   = hit_max ? (max_ext < min_ext) : (value_q < min_ext);
    clamp_res = value_q[DAC_WIDTH-1:0];
    if (hit_max) clamp_res = max_q;
    if (hit_min) clamp_res = min_q;
  end

  // Slew: delta needs one extra bit; the stepped result always lies between last and target.
  logic signed [DAC_WIDTH:0]   delta, mag;
  logic                        limit;
  logic signed [DAC_WIDTH-1:0] slew_res;

  always_comb begin
    delta    = {target_q[DAC_WIDTH-1], target_q} - {last_q[DAC_WIDTH-1], last_q};
    mag      = delta[DAC_WIDTH] ? -delta : delta;
    limit    = (step_q != '0) && (mag > {1'b0, step_q});
    slew_res = target_q;
    if (limit) slew_res = delta[DAC_WIDTH] ? (last_q - step_q) : (last_q + step_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: state_d = StClamp;
      StClamp: state_d = StSlew;
      StSlew:  state_d = StArm;
      StArm:   if (i_dac_finished || expired) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b1;
      value_q   <= '0;
      shift_q   <= '0;
      max_q     <= '0;
      min_q     <= '0;
      step_q    <= '0;
      target_q  <= '0;
      last_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      arm_q     <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= i_valid;
      done_q  <= 1'b0;
      if (start && (state_q != StIdle)) overrun_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (start) begin
            value_q <= i_pd_out;
            shift_q <= i_shift;
            max_q   <= i_max;
            min_q   <= i_min;
            step_q  <= i_max_step;
          end
        end
        StShift: value_q <= value_q >>> shift_q;
        StClamp: begin
          target_q  <= clamp_res;
          clamped_q <= hit_max | hit_min;
        end
        StSlew: begin
          data_q <= slew_res;
          arm_q  <= 1'b1;
          cnt_q  <= '0;
        end
        StArm: begin
          if (i_dac_finished) begin
            arm_q  <= 1'b0;
            last_q <= data_q;
            done_q <= 1'b1;
          end else if (expired) begin
            arm_q     <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dac_data = data_q;
  assign o_dac_arm  = arm_q;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;
  assign o_clamped  = clamped_q;
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_pd_output_stage.sv
// Bench for pd_output_stage: an arithmetic model of each update checked every cycle,
// plus directed scenarios with hand-computed codes.
module tb_pd_output_stage;

  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] i_pd_out = '0;
  logic               i_valid = 1'b0;
  logic        [4:0]  i_shift = '0;
  logic signed [19:0] i_max = 20'sd200000;
  logic signed [19:0] i_min = -20'sd200000;
  logic        [19:0] i_max_step = '0;
  logic               i_dac_finished = 1'b0;
  logic signed [19:0] o_dac_data;
  logic               o_dac_arm, o_busy, o_done, o_clamped, o_overrun, o_timeout;

  pd_output_stage #(
    .IN_WIDTH       (32),
    .DAC_WIDTH      (20),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pd_out       (i_pd_out),
    .i_valid        (i_valid),
    .i_shift        (i_shift),
    .i_max          (i_max),
    .i_min          (i_min),
    .i_max_step     (i_max_step),
    .i_dac_finished (i_dac_finished),
    .o_dac_data     (o_dac_data),
    .o_dac_arm      (o_dac_arm),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_clamped      (o_clamped),
    .o_overrun      (o_overrun),
    .o_timeout      (o_timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int done_seen = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
  endtask

  // Model: each update is computed as a whole at its start, then released on the spec timeline.
  bit     m_init = 0;
  bit     m_vprev = 1;
  int     m_phase = -1;         // -1 idle, else cycles since start (3 = armed)
  int     m_arm_n;
  longint m_code, m_last = 0, m_data = 0;
  bit     m_cflag, m_arm = 0, m_done = 0, m_clamped = 0, m_ovr = 0, m_to = 0;

  function automatic longint floor_shift(input longint v, input int sh);
    longint d, q;
    d = longint'(1) << sh;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_latch();
    longint s, mx, mn, st, t, dl, ad;
    s  = floor_shift(longint'(i_pd_out), int'(i_shift));
    mx = longint'(i_max);
    mn = longint'(i_min);
    st = longint'(i_max_step);
    t  = s;
    m_cflag = 0;
    if (t > mx) begin t = mx; m_cflag = 1; end
    if (t < mn) begin t = mn; m_cflag = 1; end
    dl = t - m_last;
    ad = (dl < 0) ? -dl : dl;
    if (st != 0 && ad > st) m_code = (dl > 0) ? m_last + st : m_last - st;
    else m_code = t;
  endtask

  task automatic model_step();
    bit start;
    if (reset) begin
      m_init = 1; m_vprev = 1; m_phase = -1; m_last = 0; m_data = 0;
      m_arm = 0; m_done = 0; m_clamped = 0; m_ovr = 0; m_to = 0;
      return;
    end
    start  = i_valid && !m_vprev;
    m_done = 0;
    if (m_phase < 0) begin
      if (start) begin model_latch(); m_phase = 0; end
    end else begin
      if (start) m_ovr = 1;
      if (m_phase < 3) begin
        m_phase++;
        if (m_phase == 2) m_clamped = m_cflag;
        if (m_phase == 3) begin m_data = m_code; m_arm = 1; m_arm_n = 0; end
      end else begin
        m_arm_n++;
        if (i_dac_finished) begin
          m_arm = 0; m_last = m_data; m_done = 1; m_phase = -1;
        end else if (m_arm_n == TO + 1) begin
          m_arm = 0; m_to = 1; m_phase = -1;
        end
      end
    end
    m_vprev = i_valid;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (o_done === 1'b1) done_seen++;
    if (m_init) begin
      check("data",    longint'(o_dac_data), m_data);
      check("arm",     longint'(o_dac_arm),  longint'(m_arm));
      check("busy",    longint'(o_busy),     longint'(m_phase >= 0));
      check("done",    longint'(o_done),     longint'(m_done));
      check("clamped", longint'(o_clamped),  longint'(m_clamped));
      check("overrun", longint'(o_overrun),  longint'(m_ovr));
      check("timeout", longint'(o_timeout),  longint'(m_to));
    end
  end

  task automatic start_update(input longint pd, input int sh, input longint mx, input longint mn,
                              input longint st);
    @(negedge clk);
    i_pd_out = 32'(pd); i_shift = 5'(sh); i_max = 20'(mx); i_min = 20'(mn);
    i_max_step = 20'(st); i_valid = 1'b1;
    @(negedge clk);
    // Scramble parameters after the latch; the update must not see them.
    i_valid = 1'b0; i_pd_out = 32'h5A5A5A5A; i_shift = 5'd7; i_max_step = 20'd1;
  endtask

  task automatic wait_arm(input string name);
    int n = 0;
    while (!o_dac_arm && n < 20) begin @(negedge clk); n++; end
    check({name, "_arm_seen"}, longint'(o_dac_arm), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 40) begin @(negedge clk); n++; end
    check({name, "_idle"}, longint'(o_busy), 0);
  endtask

  task automatic finish_handshake(input int delay);
    repeat (delay) @(negedge clk);
    i_dac_finished = 1'b1;
    @(negedge clk);
    i_dac_finished = 1'b0;
  endtask

  task automatic update(input string name, input longint pd, input int sh, input longint mx,
                        input longint mn, input longint st, input longint exp_data,
                        input longint exp_clamp);
    start_update(pd, sh, mx, mn, st);
    wait_arm(name);
    check({name, "_data"}, longint'(o_dac_data), exp_data);
    check({name, "_clamped"}, longint'(o_clamped), exp_clamp);
    finish_handshake(2);
    check({name, "_done"}, longint'(o_done), 1);
    wait_idle(name);
  endtask

  initial begin
    int d0, n;
    // Valid held high through reset release must not start an update.
    i_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_data", longint'(o_dac_data), 0);
    check("rst_arm", longint'(o_dac_arm), 0);
    repeat (4) @(negedge clk);
    check("valid_at_reset_busy", longint'(o_busy), 0);
    i_valid = 1'b0;
    @(negedge clk);

    update("scale",   65536,        4, 200000, -200000, 0,    4096,   0);
    update("neg",     -100,         3, 200000, -200000, 0,    -13,    0);
    update("sat",     32'h7FFFFFFF, 0, 200000, -200000, 0,    200000, 1);
    update("inv_win", 4,            0, 3,      5,       0,    5,      1);
    update("zero",    0,            0, 200000, -200000, 0,    0,      0);
    update("slew1",   5000,         0, 200000, -200000, 1000, 1000,   0);
    update("slew2",   5000,         0, 200000, -200000, 1000, 2000,   0);
    update("slew3",   5000,         0, 200000, -200000, 1000, 3000,   0);
    update("noslew",  5000,         0, 200000, -200000, 0,    5000,   0);

    // Overrun: second rising edge while armed is dropped.
    d0 = done_seen;
    start_update(64, 0, 200000, -200000, 0);
    wait_arm("ovr");
    @(negedge clk);
    i_pd_out = 999; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    finish_handshake(2);
    wait_idle("ovr");
    repeat (6) @(negedge clk);
    check("ovr_flag", longint'(o_overrun), 1);
    check("ovr_data", longint'(o_dac_data), 64);
    check("ovr_one_done", longint'(done_seen - d0), 1);

    // Timeout: no finished; arm held TO+1 cycles, last stays 64.
    d0 = done_seen;
    start_update(300, 0, 200000, -200000, 100);
    wait_arm("to");
    check("to_data", longint'(o_dac_data), 164);
    n = 1;
    while (o_dac_arm && n < 40) begin @(negedge clk); if (o_dac_arm) n++; end
    check("to_arm_cycles", longint'(n), TO + 1);
    check("to_flag", longint'(o_timeout), 1);
    check("to_no_done", longint'(done_seen - d0), 0);
    wait_idle("to");
    update("after_to", 300, 0, 200000, -200000, 100, 164, 0);

    // Reset while armed.
    start_update(7, 0, 200000, -200000, 0);
    wait_arm("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_arm", longint'(o_dac_arm), 0);
    check("rst_mid_busy", longint'(o_busy), 0);
    check("rst_mid_data", longint'(o_dac_data), 0);
    check("rst_mid_sticky", longint'(o_overrun | o_timeout), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
